gaus_line_fetch: RTL and testbench

// - Read-side sequencer for the Gaussian line-buffer RAM (64-bit words, 8 px x 8 bit).
// - Drives the RAM read address and absorbs its fixed 3-cycle read latency.
// - Emits one 3-row vertical bundle (top/mid/bot words) per word column, raster order, for one frame.
// - Feeds the downstream 3x3 Gaussian kernel through a valid/ready stream with backpressure.

---
 rtl/gaus_line_fetch.sv | 196 +++++++++++++++++++
 tb/tb_gaus_line_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gaus_line_fetch.sv
// rtl/gaus_line_fetch.sv - Gaussian line-buffer read sequencer emitting 3-row vertical bundles
module gaus_line_fetch #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 20,
    parameter int WORDS_PER_LINE = 80,
    parameter int NUM_LINES      = 480,
    parameter int RD_LATENCY     = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_frame_base,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_top,
    output logic [DATA_WIDTH-1:0] o_out_mid,
    output logic [DATA_WIDTH-1:0] o_out_bot,
    output logic                  o_out_eol,
    output logic                  o_out_eof
);

    localparam int W_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int Y_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int P_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [Y_W-1:0]        r_y;
    logic [W_W-1:0]        r_w;
    logic [1:0]            r_phase;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    // tag layout: {valid, phase[1:0], eol, eof}
    logic [4:0]            r_tag [0:RD_LATENCY];
    logic [DATA_WIDTH-1:0] r_top;
    logic [DATA_WIDTH-1:0] r_mid;
    logic [DATA_WIDTH-1:0] r_mem_top [0:FIFO_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_mem_mid [0:FIFO_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_mem_bot [0:FIFO_DEPTH-1];
    logic [1:0]            r_mem_flag [0:FIFO_DEPTH-1];
    logic [P_W-1:0]        r_wr_ptr;
    logic [P_W-1:0]        r_rd_ptr;
    logic [C_W-1:0]        r_count;
    logic [C_W-1:0]        r_inflight;

    logic                  w_last_col;
    logic                  w_last_line;
    logic [C_W:0]          w_pending;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_issue_p0;
    logic [Y_W-1:0]        w_line;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [4:0]            w_tag_out;
    logic                  w_fifo_wr;
    logic                  w_fifo_rd;
    logic                  w_drained;

    assign w_last_col  = (r_w == W_W'(WORDS_PER_LINE - 1));
    assign w_last_line = (r_y == Y_W'(NUM_LINES - 1));
    assign w_pending   = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_credit    = (w_pending < (C_W + 1)'(FIFO_DEPTH));
    // The start cycle itself issues the first top read so the address is out one cycle later.
    assign w_issue     = ((r_state == S_IDLE) && i_start) ||
                         ((r_state == S_ISSUE) && ((r_phase != 2'd0) || w_credit));
    assign w_issue_p0  = w_issue && (r_phase == 2'd0);
    assign w_base      = (r_state == S_IDLE) ? i_frame_base : r_base;
    assign w_addr      = w_base + ADDR_WIDTH'(w_line) * ADDR_WIDTH'(WORDS_PER_LINE) + ADDR_WIDTH'(r_w);
    assign w_tag_out   = r_tag[RD_LATENCY];
    assign w_fifo_wr   = w_tag_out[4] && (w_tag_out[3:2] == 2'd2);
    assign w_fifo_rd   = o_out_valid && i_out_ready;
    assign w_drained   = (r_count == '0) && (r_inflight == '0);

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DRAIN) && w_drained;
    assign o_rd_addr   = r_rd_addr;
    assign o_out_valid = (r_count != '0);
    assign o_out_top   = r_mem_top[r_rd_ptr];
    assign o_out_mid   = r_mem_mid[r_rd_ptr];
    assign o_out_bot   = r_mem_bot[r_rd_ptr];
    assign o_out_eol   = o_out_valid && r_mem_flag[r_rd_ptr][1];
    assign o_out_eof   = o_out_valid && r_mem_flag[r_rd_ptr][0];

    // Source line for the current phase, replicating the first/last line at the frame edges
    always_comb begin
        w_line = r_y;
        if ((r_phase == 2'd0) && (r_y != '0)) begin
            w_line = r_y - Y_W'(1);
        end else if ((r_phase == 2'd2) && !w_last_line) begin
            w_line = r_y + Y_W'(1);
        end
    end

    // Frame FSM, column/line/phase counters and the registered read address
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_phase   <= 2'd0;
            r_rd_addr <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_base  <= i_frame_base;
                r_state <= S_ISSUE;
            end
            if (w_issue) begin
                r_rd_addr <= w_addr;
                if (r_phase == 2'd2) begin
                    r_phase <= 2'd0;
                    if (w_last_col) begin
                        r_w <= '0;
                        if (w_last_line) begin
                            r_y     <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_y <= r_y + Y_W'(1);
                        end
                    end else begin
                        r_w <= r_w + W_W'(1);
                    end
                end else begin
                    r_phase <= r_phase + 2'd1;
                end
            end
            if ((r_state == S_DRAIN) && w_drained) begin
                r_state <= S_IDLE;
            end
        end
    end

    // Tag pipe aligns each issued read with its RAM data RD_LATENCY cycles later
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                r_tag[i] <= 5'd0;
            end
        end else begin
            r_tag[0] <= {w_issue, r_phase, w_last_col, w_last_col && w_last_line};
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Hold the top and mid words until the bottom word completes the bundle
    always_ff @(posedge i_clk) begin
        if (w_tag_out[4] && (w_tag_out[3:2] == 2'd0)) begin
            r_top <= i_rd_data;
        end
        if (w_tag_out[4] && (w_tag_out[3:2] == 2'd1)) begin
            r_mid <= i_rd_data;
        end
    end

    // Bundle FIFO storage; the bottom word goes straight from the RAM into the entry
    always_ff @(posedge i_clk) begin
        if (w_fifo_wr) begin
            r_mem_top[r_wr_ptr]  <= r_top;
            r_mem_mid[r_wr_ptr]  <= r_mid;
            r_mem_bot[r_wr_ptr]  <= i_rd_data;
            r_mem_flag[r_wr_ptr] <= w_tag_out[1:0];
        end
    end

    // FIFO pointers, occupancy and in-flight bundle count that together form the read credit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + P_W'(1);
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= r_rd_ptr + P_W'(1);
            end
            r_count    <= r_count + C_W'(w_fifo_wr) - C_W'(w_fifo_rd);
            r_inflight <= r_inflight + C_W'(w_issue_p0) - C_W'(w_fifo_wr);
        end
    end

endmodule

// File: tb/tb_gaus_line_fetch.sv
// tb/tb_gaus_line_fetch.sv - randomized self-checking bench for gaus_line_fetch
module tb_gaus_line_fetch;

    localparam int WPL   = 4;
    localparam int NL    = 3;
    localparam int TOTAL = WPL * NL;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] frame_base;
    logic        busy;
    logic        done;
    logic [19:0] rd_addr;
    logic [63:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_top;
    logic [63:0] out_mid;
    logic [63:0] out_bot;
    logic        out_eol;
    logic        out_eof;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_done   = 0;
    int last_acc_cyc = 0;
    int done_cyc     = 0;
    logic [19:0] mon_base = 20'h0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_top, prev_mid, prev_bot;
    logic [19:0] a1, a2, saved_addr;

    gaus_line_fetch #(
        .DATA_WIDTH(64), .ADDR_WIDTH(20), .WORDS_PER_LINE(WPL),
        .NUM_LINES(NL), .RD_LATENCY(3), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_frame_base(frame_base),
        .o_busy(busy), .o_done(done), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_top(out_top), .o_out_mid(out_mid), .o_out_bot(out_bot),
        .o_out_eol(out_eol), .o_out_eof(out_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: q equals the address presented three cycles earlier
    always @(posedge clk) begin
        a1      <= rd_addr;
        a2      <= a1;
        rd_data <= {44'd0, a2};
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ram_word(input logic [19:0] base, input int line, input int w);
        logic [19:0] a;
        a = base + 20'(line * WPL + w);
        return {44'd0, a};
    endfunction

    // Reference: bundle k is column k%WPL of line k/WPL with clamped neighbour lines
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
                check_eq("hold_top", out_top, prev_top);
                check_eq("hold_mid", out_mid, prev_mid);
                check_eq("hold_bot", out_bot, prev_bot);
            end
            if (out_valid && out_ready) begin
                if (n_acc >= TOTAL) begin
                    check_eq("extra_bundle", 64'(n_acc), 64'(TOTAL - 1));
                end else begin
                    int y, w, lt, lb;
                    y  = n_acc / WPL;
                    w  = n_acc % WPL;
                    lt = (y > 0) ? y - 1 : 0;
                    lb = (y < NL - 1) ? y + 1 : NL - 1;
                    check_eq("top", out_top, ram_word(mon_base, lt, w));
                    check_eq("mid", out_mid, ram_word(mon_base, y, w));
                    check_eq("bot", out_bot, ram_word(mon_base, lb, w));
                    check_eq("eol_eof", {62'd0, out_eol, out_eof},
                             {62'd0, w == WPL - 1, n_acc == TOTAL - 1});
                end
                n_acc++;
                last_acc_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_top = out_top;
            prev_mid = out_mid;
            prev_bot = out_bot;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [19:0] base);
        frame_base = base;
        mon_base   = base;
        n_acc      = 0;
        n_done     = 0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready, input int bound);
        for (int i = 0; i < bound && n_done == 0; i++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 99) < 60);
            tick();
        end
        out_ready = 1'b1;
        check_eq("done_seen", 64'(n_done), 64'd1);
        check_eq("done_after_accept", 64'(done_cyc), 64'(last_acc_cyc + 1));
        repeat (5) tick();
        check_eq("bundle_count", 64'(n_acc), 64'(TOTAL));
        check_eq("done_count", 64'(n_done), 64'd1);
        check_eq("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frame_base = 20'h0; out_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_flags", {62'd0, out_eol, out_eof}, 64'd0);
        check_eq("rst_addr", {44'd0, rd_addr}, 64'd0);
        rst = 1'b0;
        tick();

        // basic frame and first-bundle latency
        start_frame(20'h100);
        check_eq("c1_busy", {63'd0, busy}, 64'd1);
        check_eq("c1_addr", {44'd0, rd_addr}, 64'h100);
        tick();
        check_eq("c2_addr", {44'd0, rd_addr}, 64'h100);
        tick();
        check_eq("c3_addr", {44'd0, rd_addr}, 64'h104);
        repeat (3) tick();
        check_eq("c6_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check_eq("c7_valid", {63'd0, out_valid}, 64'd1);
        wait_done(1'b0, 500);

        // backpressure: credit limits buffering to four bundles
        out_ready = 1'b0;
        start_frame(20'h100);
        repeat (14) tick();
        saved_addr = rd_addr;
        repeat (5) tick();
        check_eq("stall_addr", {44'd0, rd_addr}, 64'h107);
        check_eq("stall_addr_stable", {44'd0, rd_addr}, {44'd0, saved_addr});
        check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
        check_eq("stall_no_accept", 64'(n_acc), 64'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        check_eq("buffered_four", 64'(n_acc), 64'd4);
        check_eq("buffer_empty", {63'd0, out_valid}, 64'd0);
        wait_done(1'b0, 500);

        // address truncation
        start_frame(20'hFFFFE);
        check_eq("wrap_a1", {44'd0, rd_addr}, 64'hFFFFE);
        tick(); tick();
        check_eq("wrap_a3", {44'd0, rd_addr}, 64'h00002);
        wait_done(1'b0, 500);

        // reset mid-frame, then rst beating start, then a clean frame
        start_frame(20'h100);
        for (int i = 0; i < 200 && n_acc < 5; i++) tick();
        check_eq("reached_b5", 64'(n_acc), 64'd5);
        rst = 1'b1;
        tick();
        check_eq("abort_valid", {63'd0, out_valid}, 64'd0);
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("rst_beats_start", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        tick();
        start_frame(20'h100);
        wait_done(1'b0, 500);

        // start while busy is ignored
        start_frame(20'h100);
        repeat (5) tick();
        frame_base = 20'h500; start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(1'b0, 500);
        repeat (30) tick();
        check_eq("busy_start_bundles", 64'(n_acc), 64'(TOTAL));
        check_eq("busy_start_dones", 64'(n_done), 64'd1);

        // randomized bases and backpressure
        for (int f = 0; f < 6; f++) begin
            start_frame(20'($urandom));
            wait_done(1'b1, 3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
